szcv_flag_unit: RTL and testbench
=================================

Name: szcv_flag_unit

Overview:
Parametrised successor to the per-phase SZCV enable decode. The block owns the one-hot phase ring and decodes ALU-class instructions. It computes the S/Z/C/V flags from ALU operands and result, holds them in a flag register, and evaluates conditional-branch conditions. It sits between the instruction register, the ALU and the PC-select logic of the multi-phase 16-bit core.

Parameters:
DATA_W, 16, ALU operand/result width (>=2)
NPHASE, 5, number of one-hot phases in the ring (>=2)
UPD_PH, 2, phase index in which flags are written (0..NPHASE-1)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
stall  input  1  holds the phase ring and suppresses the flag write
instr  input  16  current instruction
alu_a  input  DATA_W  ALU operand A
alu_b  input  DATA_W  ALU operand B
alu_y  input  DATA_W  ALU result
alu_cout  input  1  ALU carry/borrow out (last bit shifted out for shifts)
flag_save  input  1  shadow save request (feature only)
flag_restore  input  1  shadow restore request (feature only)
phase  output  NPHASE  one-hot phase
szcv  output  4  registered flags {S,Z,C,V}
szcv_enable  output  1  flag write strobe for this cycle
branch_taken  output  1  condition true for the current branch instruction
halted  output  1  sticky halt indicator

Behaviour:
- One clock, synchronous active-high reset on rst. Reset values: phase=1 (bit0), szcv=0, halted=0, shadow=0.
- Phase ring advances one bit per clk when stall=0 and halted=0. It wraps from bit NPHASE-1 to bit0. It holds while stall=1 or halted=1.
- ALU class: instr[15:14]==2'b11. The op is instr[7:4]:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 CMP, 0110 MOV
  - 1000 SLL, 1001 SLR, 1010 SRL, 1011 SRA
  - 1100 IN, 1101 OUT, 1111 HLT
- flag_op = ALU class and op not in {IN, OUT, HLT, 0111, 1110}.
- szcv_enable = phase[UPD_PH] & flag_op & ~stall & ~halted. It is combinational. The flags register on the clk edge where it is high.
- Flag values:
  - S = alu_y[DATA_W-1]
  - Z = (alu_y == 0)
  - C = alu_cout for ADD/SUB/CMP/shifts, else 0
  - V (ADD) = (a_msb == b_msb) & (y_msb != a_msb)
  - V (SUB/CMP) = (a_msb != b_msb) & (y_msb != a_msb)
  - V (all other ops) = 0
- Stall in UPD_PH: no write while stalled. The write happens on the cycle the ring leaves UPD_PH.
- Halt: HLT decoded while phase[UPD_PH] & ~stall sets halted=1 on that edge. The ring freezes at the next phase and szcv_enable stays 0. Only rst clears halted.
- Branch: instr[15:11]==5'b10111. The condition is instr[10:8]:
  - 000 BE: Z
  - 001 BLT: S^V
  - 010 BLE: Z|(S^V)
  - 011 BNE: ~Z
  - others: 0
- branch_taken is combinational from the registered szcv, independent of phase. It is 0 for non-branch instructions.
- Reset mid-operation: all state returns to reset values on the next edge, and any pending flag write is discarded.

Optional Feature:
SZCV_SHADOW_EN:
- Defined: a 4-bit shadow register is implemented.
  - flag_save=1 copies the current szcv (pre-update value) into shadow.
  - flag_restore=1 loads shadow into szcv and takes priority over a simultaneous ALU flag write.
  - Save and restore on the same edge swap the two values.
- Undefined: the flag_save and flag_restore ports exist but are ignored, and no shadow register is built.

Test Plan:
- Reset, then 7 unstalled cycles with NPHASE=5 -> phase sequence 1,2,4,8,16,1,2,4; szcv=0.
- ADD, a=16'h7FFF, b=16'h0001, y=16'h8000, cout=0, in phase 2 -> szcv_enable=1 for that cycle only; next cycle szcv=4'b1001.
- CMP, a=16'h0005, b=16'h0005, y=0, cout=1 -> szcv=4'b0110. Then BE (instr=16'hB800) -> branch_taken=1; BNE (16'hBB00) -> 0.
- Hold stall=1 for 3 cycles at phase 4 with SUB decoded -> phase and szcv unchanged and szcv_enable=0. Release -> write occurs and phase advances to 8.
- HLT (16'hC0F0) at phase 2 -> halted=1 and phase stuck at 8. IN (16'hC0C0) in phase 2 -> szcv_enable=0. Asserting rst -> phase=1, halted=0.
- With SZCV_SHADOW_EN: szcv=4'b0110, flag_save; later restore together with an ADD update -> szcv=4'b0110.

Source files
------------

// File: rtl/szcv_flag_unit_if.sv
// ALU/instruction bus seen by the SZCV flag unit.
// The core drives through master; the flag unit consumes through slave.
interface szcv_flag_unit_if #(
  parameter int DATA_W = 16,
  parameter int NPHASE = 5
);
  logic              stall;
  logic [15:0]       instr;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic              alu_cout;
  logic              flag_save;
  logic              flag_restore;
  logic [NPHASE-1:0] phase;
  logic [3:0]        szcv;
  logic              szcv_enable;
  logic              branch_taken;
  logic              halted;

  modport master (
    output stall,
    output instr,
    output alu_a,
    output alu_b,
    output alu_y,
    output alu_cout,
    output flag_save,
    output flag_restore,
    input  phase,
    input  szcv,
    input  szcv_enable,
    input  branch_taken,
    input  halted
  );

  modport slave (
    input  stall,
    input  instr,
    input  alu_a,
    input  alu_b,
    input  alu_y,
    input  alu_cout,
    input  flag_save,
    input  flag_restore,
    output phase,
    output szcv,
    output szcv_enable,
    output branch_taken,
    output halted
  );
endinterface

// File: rtl/szcv_flag_unit.sv
// Phase ring, ALU flag decode/register and branch condition evaluation.
// Optional flag shadow register: define SZCV_SHADOW_EN.
module szcv_flag_unit #(
  parameter int DATA_W = 16,
  parameter int NPHASE = 5,
  parameter int UPD_PH = 2
) (
  input  logic            clk,
  input  logic            rst,
  szcv_flag_unit_if.slave bus
);

  logic [NPHASE-1:0] phase_q;
  logic [NPHASE-1:0] phase_d;
  logic              halted_q;
  logic              halted_d;
  logic [3:0]        szcv_q;
  logic [3:0]        szcv_d;

  logic [3:0] op;
  logic       alu_cls;
  logic       op_add;
  logic       op_sub;
  logic       op_shf;
  logic       op_log;
  logic       op_hlt;
  logic       flag_op;
  logic       go;
  logic       upd_ph;
  logic       wr_en;
  logic       hlt_fire;

  logic       s_new;
  logic       z_new;
  logic       c_new;
  logic       v_new;
  logic       a_msb;
  logic       b_msb;
  logic       y_msb;

  logic       is_br;
  logic       cond;

  assign op      = bus.instr[7:4];
  assign alu_cls = (bus.instr[15:14] == 2'b11);
  assign a_msb   = bus.alu_a[DATA_W-1];
  assign b_msb   = bus.alu_b[DATA_W-1];
  assign y_msb   = bus.alu_y[DATA_W-1];

  always_comb begin
    op_add = 1'b0;
    op_sub = 1'b0;
    op_shf = 1'b0;
    op_log = 1'b0;
    op_hlt = 1'b0;
    unique case (1'b1)
      (op == 4'b0000):                   op_add = 1'b1;
      (op == 4'b0001), (op == 4'b0101):  op_sub = 1'b1;
      (op[3:2] == 2'b10):                op_shf = 1'b1;
      (op == 4'b0010), (op == 4'b0011),
      (op == 4'b0100), (op == 4'b0110):  op_log = 1'b1;
      (op == 4'b1111):                   op_hlt = 1'b1;
      default: ;
    endcase
  end

  assign flag_op  = alu_cls & (op_add | op_sub | op_shf | op_log);
  assign go       = ~bus.stall & ~halted_q;
  assign upd_ph   = phase_q[UPD_PH];
  assign wr_en    = upd_ph & flag_op & go;
  assign hlt_fire = upd_ph & alu_cls & op_hlt & ~bus.stall;

  always_comb begin
    s_new = y_msb;
    z_new = ~|bus.alu_y;
    c_new = 1'b0;
    v_new = 1'b0;
    unique case (1'b1)
      op_add: begin
        c_new = bus.alu_cout;
        v_new = (a_msb == b_msb) & (y_msb != a_msb);
      end
      op_sub: begin
        c_new = bus.alu_cout;
        v_new = (a_msb != b_msb) & (y_msb != a_msb);
      end
      op_shf:  c_new = bus.alu_cout;
      default: ;
    endcase
  end

  // Phase ring and sticky halt form the sequencing state.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= NPHASE'(1);
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q | hlt_fire;
    if (go) begin
      phase_d = {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
    end
  end

`ifdef SZCV_SHADOW_EN
  logic [3:0] shadow_q;
  logic [3:0] shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (bus.flag_save) begin
      shadow_d = szcv_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= 4'b0000;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Restore beats a same-cycle ALU write; with save it swaps.
  always_comb begin
    szcv_d = szcv_q;
    if (bus.flag_restore) begin
      szcv_d = shadow_q;
    end else if (wr_en) begin
      szcv_d = {s_new, z_new, c_new, v_new};
    end
  end
`else
  logic unused_shadow;
  assign unused_shadow = bus.flag_save ^ bus.flag_restore;

  always_comb begin
    szcv_d = szcv_q;
    if (wr_en) begin
      szcv_d = {s_new, z_new, c_new, v_new};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      szcv_q <= 4'b0000;
    end else begin
      szcv_q <= szcv_d;
    end
  end

  assign is_br = (bus.instr[15:11] == 5'b10111);

  always_comb begin
    cond = 1'b0;
    unique case (bus.instr[10:8])
      3'b000:  cond = szcv_q[2];
      3'b001:  cond = szcv_q[3] ^ szcv_q[0];
      3'b010:  cond = szcv_q[2] | (szcv_q[3] ^ szcv_q[0]);
      3'b011:  cond = ~szcv_q[2];
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    bus.phase        = phase_q;
    bus.halted       = halted_q;
    bus.szcv         = szcv_q;
    bus.szcv_enable  = wr_en;
    bus.branch_taken = is_br & cond;
  end

  logic unused_bits;
  assign unused_bits = ^{bus.instr[3:0],
                         bus.alu_a[DATA_W-2:0],
                         bus.alu_b[DATA_W-2:0]};

endmodule

// File: tb/tb_szcv_flag_unit.sv
// Directed bench for szcv_flag_unit with NPHASE=5, UPD_PH=2.
// Build with SZCV_SHADOW_EN to exercise the shadow register path.
module tb_szcv_flag_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  szcv_flag_unit_if #(.DATA_W(16), .NPHASE(5)) bus ();

  szcv_flag_unit #(
    .DATA_W(16),
    .NPHASE(5),
    .UPD_PH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] ins, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] y,
                       input logic co);
    bus.instr    = ins;
    bus.alu_a    = a;
    bus.alu_b    = b;
    bus.alu_y    = y;
    bus.alu_cout = co;
    #1;
  endtask

  task automatic goto_upd();
    int n;
    n = 0;
    drive(16'h0000, 16'h0, 16'h0, 16'h0, 1'b0);
    while (bus.phase !== 5'b00100 && n < 8) begin
      tick();
      n++;
    end
    chk("reach_upd", 32'(bus.phase), 32'h4);
  endtask

  logic [4:0] exp_ph [7];

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.stall    = 1'b0;
    bus.flag_save    = 1'b0;
    bus.flag_restore = 1'b0;
    drive(16'h0000, 16'h0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_phase", 32'(bus.phase), 32'h1);
    chk("rst_szcv", 32'(bus.szcv), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);

    exp_ph = '{5'd2, 5'd4, 5'd8, 5'd16, 5'd1, 5'd2, 5'd4};
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("ring%0d", i), 32'(bus.phase), 32'(exp_ph[i]));
    end
    chk("ring_szcv", 32'(bus.szcv), 32'h0);

    // ADD overflow: 7FFF + 1
    drive(16'hC000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
    chk("add_en", 32'(bus.szcv_enable), 32'h1);
    tick();
    chk("add_en_off", 32'(bus.szcv_enable), 32'h0);
    chk("add_szcv", 32'(bus.szcv), 32'h9);
    chk("add_phase", 32'(bus.phase), 32'h8);

    goto_upd();
    drive(16'hC050, 16'h0005, 16'h0005, 16'h0000, 1'b1);
    tick();
    chk("cmp_szcv", 32'(bus.szcv), 32'h6);
    drive(16'hB800, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("br_be", 32'(bus.branch_taken), 32'h1);
    drive(16'hB900, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("br_blt", 32'(bus.branch_taken), 32'h0);
    drive(16'hBA00, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("br_ble", 32'(bus.branch_taken), 32'h1);
    drive(16'hBB00, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("br_bne", 32'(bus.branch_taken), 32'h0);
    drive(16'hBC00, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("br_other", 32'(bus.branch_taken), 32'h0);
    drive(16'h3800, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("br_nonbr", 32'(bus.branch_taken), 32'h0);

    // SUB overflow held by stall in the update phase
    goto_upd();
    drive(16'hC010, 16'h8000, 16'h0001, 16'h7FFF, 1'b0);
    bus.stall = 1'b1;
    #1;
    chk("stall_en", 32'(bus.szcv_enable), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_ph%0d", i), 32'(bus.phase), 32'h4);
      chk($sformatf("stall_sz%0d", i), 32'(bus.szcv), 32'h6);
      chk($sformatf("stall_en%0d", i), 32'(bus.szcv_enable), 32'h0);
    end
    bus.stall = 1'b0;
    #1;
    chk("unstall_en", 32'(bus.szcv_enable), 32'h1);
    tick();
    chk("sub_szcv", 32'(bus.szcv), 32'h1);
    chk("sub_phase", 32'(bus.phase), 32'h8);

    // AND with a carry-out present: C must be 0
    goto_upd();
    drive(16'hC020, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1);
    tick();
    chk("and_szcv", 32'(bus.szcv), 32'h4);

    // SRA keeps the shifted-out bit in C
    goto_upd();
    drive(16'hC0B0, 16'h8001, 16'h0001, 16'hC000, 1'b1);
    tick();
    chk("sra_szcv", 32'(bus.szcv), 32'hA);

    goto_upd();
    drive(16'hC0C0, 16'h1234, 16'h0, 16'h0000, 1'b1);
    chk("in_en", 32'(bus.szcv_enable), 32'h0);
    tick();
    chk("in_szcv", 32'(bus.szcv), 32'hA);

    goto_upd();
    drive(16'hC0F0, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("hlt_en", 32'(bus.szcv_enable), 32'h0);
    tick();
    chk("hlt_halted", 32'(bus.halted), 32'h1);
    chk("hlt_phase", 32'(bus.phase), 32'h8);
    drive(16'hC000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("hlt_frozen", 32'(bus.phase), 32'h8);
    chk("hlt_sticky", 32'(bus.halted), 32'h1);
    chk("hlt_szcv", 32'(bus.szcv), 32'hA);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_phase", 32'(bus.phase), 32'h1);
    chk("rst2_halted", 32'(bus.halted), 32'h0);
    chk("rst2_szcv", 32'(bus.szcv), 32'h0);

    // Reset discards a write pending in the update phase
    goto_upd();
    drive(16'hC000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
    chk("pend_en", 32'(bus.szcv_enable), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("pend_szcv", 32'(bus.szcv), 32'h0);
    chk("pend_phase", 32'(bus.phase), 32'h1);

    // Save 0110, then restore alongside an ADD update
    goto_upd();
    drive(16'hC050, 16'h0005, 16'h0005, 16'h0000, 1'b1);
    tick();
    chk("sh_cmp", 32'(bus.szcv), 32'h6);
    bus.flag_save = 1'b1;
    tick();
    bus.flag_save = 1'b0;
    chk("sh_saved", 32'(bus.szcv), 32'h6);
    goto_upd();
    drive(16'hC000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
    bus.flag_restore = 1'b1;
    tick();
    bus.flag_restore = 1'b0;
`ifdef SZCV_SHADOW_EN
    chk("sh_restore", 32'(bus.szcv), 32'h6);
`else
    chk("sh_ignored", 32'(bus.szcv), 32'h9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
